// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl_if
// Description : Bundle of the decode inputs, memory handshake and datapath
//               control outputs between the multicycle MIPS sequencer and
//               its datapath. The master modport is the controller side; the
//               slave modport is the datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCEn;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       IllegalOp;
  logic       MemFault;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output MemReq, MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp, MemFault
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  MemReq, MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp, MemFault
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Moore sequencing FSM for the multicycle MIPS datapath with a
//               MemReq/MemReady handshake and a memory-timeout watchdog that
//               parks the core in HALT with a sticky MemFault.
//               Optional macro MULTICYCLE_EXT_OPS_EN adds addi and j.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int                 c_CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam bit                 c_WDOG_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_EXT_OPS_EN
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_HALT    = 4'd9
`ifdef MULTICYCLE_EXT_OPS_EN
    ,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_JUMP    = 4'd12
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_mem_fault;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_regwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [2:0] w_aluctl;
  logic       w_illegal;
  logic       w_stall;
  logic       w_timeout;

  // A request cycle without MemReady is a wait cycle; the watchdog fires on
  // the wait cycle that finds the counter already at the limit.
  assign w_stall   = w_mem_req & ~bus.MemReady;
  assign w_timeout = c_WDOG_EN & w_stall & (r_wait_cnt == c_TIMEOUT);

  // State register, wait counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (c_WDOG_EN && w_stall && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_mem_fault <= 1'b1;
      end
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_regwrite  = 1'b0;
    w_regdst    = 1'b0;
    w_memtoreg  = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_pcsrc     = 2'b00;
    w_aluctl    = 3'b000;
    w_illegal   = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        w_aluctl  = c_ALU_ADD;
        // IR load and PC+4 happen only on the completing cycle.
        w_irwrite = bus.MemReady;
        w_pcwrite = bus.MemReady;
        if (bus.MemReady) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_alusrcb = 2'b11;
        w_aluctl  = c_ALU_ADD;
        case (bus.Op)
          c_OP_RTYPE:       w_next = ST_EXECUTE;
          c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
          c_OP_BEQ:         w_next = ST_BRANCH;
`ifdef MULTICYCLE_EXT_OPS_EN
          c_OP_ADDI:        w_next = ST_ADDIEX;
          c_OP_J:           w_next = ST_JUMP;
`else
          // addi and j are not decoded in this build and fall to the default.
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = c_ALU_ADD;
        w_next    = (bus.Op == c_OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (bus.MemReady) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.MemReady) w_next = ST_FETCH;
      end
      ST_EXECUTE: begin
        w_alusrca = 1'b1;
        w_next    = ST_ALUWB;
        case (bus.Funct)
          6'b100000: w_aluctl = c_ALU_ADD;
          6'b100010: w_aluctl = c_ALU_SUB;
          6'b100100: w_aluctl = c_ALU_AND;
          6'b100101: w_aluctl = c_ALU_OR;
          6'b101010: w_aluctl = c_ALU_SLT;
          default: begin
            // Unknown function: skip the writeback entirely.
            w_aluctl  = c_ALU_ADD;
            w_illegal = 1'b1;
            w_next    = ST_FETCH;
          end
        endcase
      end
      ST_ALUWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluctl  = c_ALU_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_next    = ST_FETCH;
      end
`ifdef MULTICYCLE_EXT_OPS_EN
      ST_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = c_ALU_ADD;
        w_next    = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = ST_FETCH;
      end
`endif
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase

    if (w_timeout) w_next = ST_HALT;
  end

  // Every output is forced low while reset is held.
  assign bus.MemReq     = w_mem_req   & ~reset;
  assign bus.MemWrite   = w_mem_write & ~reset;
  assign bus.IorD       = w_iord      & ~reset;
  assign bus.IRWrite    = w_irwrite   & ~reset;
  assign bus.PCEn       = (w_pcwrite | (w_branch & bus.Zero)) & ~reset;
  assign bus.RegWrite   = w_regwrite  & ~reset;
  assign bus.RegDst     = w_regdst    & ~reset;
  assign bus.MemtoReg   = w_memtoreg  & ~reset;
  assign bus.ALUSrcA    = w_alusrca   & ~reset;
  assign bus.ALUSrcB    = w_alusrcb   & {2{~reset}};
  assign bus.PCSrc      = w_pcsrc     & {2{~reset}};
  assign bus.ALUControl = w_aluctl    & {3{~reset}};
  assign bus.IllegalOp  = w_illegal   & ~reset;
  assign bus.MemFault   = r_mem_fault & ~reset;

endmodule
`default_nettype wire
